// File: rtl/ghost_rand_arbiter.sv
// ghost_rand_arbiter: round-robin arbiter sharing one 16-bit XNOR LFSR
// among N_GHOST ghost AI requesters, each asking for a legal random direction.
//
// Ports:
//   i_clk        clock
//   i_rst        synchronous reset, active-high
//   i_seed_load  load i_seed into the LFSR at the next edge
//   i_seed       LFSR seed
//   i_req        per-ghost request level, held until grant
//   i_mask       legal-direction masks, ghost k in [4k+3:4k]
//   o_gnt        one-hot grant pulse (1 cycle)
//   o_dir        granted direction (0=up 1=left 2=down 3=right)
//   o_fallback   direction came from the mask, not from a random draw
//   o_busy       FSM not idle
//   o_lfsr       current LFSR state
module ghost_rand_arbiter #(
    parameter int N_GHOST = 4,
    parameter int MAX_TRY = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_seed_load,
    input  logic [15:0]            i_seed,
    input  logic [N_GHOST-1:0]     i_req,
    input  logic [4*N_GHOST-1:0]   i_mask,
    output logic [N_GHOST-1:0]     o_gnt,
    output logic [1:0]             o_dir,
    output logic                   o_fallback,
    output logic                   o_busy,
    output logic [15:0]            o_lfsr
);

    localparam int IW = (N_GHOST > 1) ? $clog2(N_GHOST) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRAW,
        S_RESP
    } state_t;

    state_t        state;
    state_t        state_nxt;

    logic [15:0]   lfsr;
    logic          lfsr_fb;

    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] idx;
    logic [IW-1:0] pick_idx;
    logic          pick_vld;
    int            pick_j;

    logic [3:0]    mask_q;
    logic [3:0]    try_cnt;
    logic [1:0]    dir_q;
    logic          fb_q;

    logic [1:0]    cand;
    logic          cand_ok;
    logic          last_try;
    logic [1:0]    lo_dir;

    // XNOR form: all-zero is a valid state, all-ones is the lock-up state
    assign lfsr_fb  = ~(lfsr[10] ^ lfsr[12] ^ lfsr[13] ^ lfsr[15]);
    assign cand     = lfsr[1:0];
    assign cand_ok  = mask_q[cand];
    assign last_try = (try_cnt == 4'(MAX_TRY - 1));
    assign o_lfsr   = lfsr;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            lfsr <= 16'h0000;
        end else if (i_seed_load) begin
            lfsr <= i_seed;
        end else begin
            lfsr <= {lfsr[14:0], lfsr_fb};
        end
    end

    // Round-robin pick: first requester after rr_ptr, wrapping
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        pick_j   = 0;
        for (int i = 1; i <= N_GHOST; i++) begin
            pick_j = (int'(rr_ptr) + i) % N_GHOST;
            if (!pick_vld && i_req[pick_j]) begin
                pick_vld = 1'b1;
                pick_idx = IW'(pick_j);
            end
        end
    end

    // Lowest legal direction for the fallback; 0 when nothing is legal
    always_comb begin
        lo_dir = 2'd0;
        for (int d = 3; d >= 0; d--) begin
            if (mask_q[d]) begin
                lo_dir = 2'(d);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (pick_vld) begin
                    state_nxt = S_DRAW;
                end
            end
            S_DRAW: begin
                if (cand_ok || last_try) begin
                    state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rr_ptr  <= IW'(N_GHOST - 1);
            idx     <= '0;
            mask_q  <= 4'd0;
            try_cnt <= 4'd0;
            dir_q   <= 2'd0;
            fb_q    <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (pick_vld) begin
                        idx     <= pick_idx;
                        mask_q  <= i_mask[4*pick_idx +: 4];
                        try_cnt <= 4'd0;
                    end
                end
                S_DRAW: begin
                    if (cand_ok) begin
                        dir_q <= cand;
                        fb_q  <= 1'b0;
                    end else if (last_try) begin
                        dir_q <= lo_dir;
                        fb_q  <= 1'b1;
                    end else begin
                        try_cnt <= try_cnt + 4'd1;
                    end
                end
                S_RESP: begin
                    rr_ptr <= idx;
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        o_gnt      = '0;
        o_dir      = 2'd0;
        o_fallback = 1'b0;
        o_busy     = (state != S_IDLE);
        if (state == S_RESP) begin
            o_gnt      = N_GHOST'(1) << idx;
            o_dir      = dir_q;
            o_fallback = fb_q;
        end
    end

endmodule

// File: tb/tb_ghost_rand_arbiter.sv
// tb_ghost_rand_arbiter: directed bench for ghost_rand_arbiter with a
// scoreboard queue of expected grants (one-hot, direction, fallback, latency).
module tb_ghost_rand_arbiter;

    logic        clk;
    logic        rst;
    logic        seed_load;
    logic [15:0] seed;
    logic [3:0]  req;
    logic [15:0] mask;
    logic [3:0]  gnt;
    logic [1:0]  dir;
    logic        fallback;
    logic        busy;
    logic [15:0] lfsr;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] gnt;
        logic [1:0] dir;
        logic       fb;
        int         lat;
    } exp_t;

    exp_t sb[$];

    ghost_rand_arbiter #(
        .N_GHOST(4),
        .MAX_TRY(4)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_seed_load(seed_load),
        .i_seed     (seed),
        .i_req      (req),
        .i_mask     (mask),
        .o_gnt      (gnt),
        .o_dir      (dir),
        .o_fallback (fallback),
        .o_busy     (busy),
        .o_lfsr     (lfsr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [3:0] g, input logic [1:0] d,
                        input logic f, input int l);
        exp_t e;
        e.gnt = g;
        e.dir = d;
        e.fb  = f;
        e.lat = l;
        sb.push_back(e);
    endtask

    // n0 = negedges already elapsed since the request was driven in IDLE
    task automatic wait_grant(input int n0, input string tag);
        exp_t e;
        int   n;
        bit   got;
        n   = n0;
        got = 1'b0;
        while (!got && n < 20) begin
            @(negedge clk);
            n++;
            if (gnt != 4'd0) got = 1'b1;
        end
        e = sb.pop_front();
        chk({tag, "_gnt"}, 32'(gnt), 32'(e.gnt));
        chk({tag, "_dir"}, 32'(dir), 32'(e.dir));
        chk({tag, "_fb"}, 32'(fallback), 32'(e.fb));
        chk({tag, "_lat"}, n, e.lat);
    endtask

    initial begin
        rst       = 1'b1;
        seed_load = 1'b0;
        seed      = 16'h0000;
        req       = 4'b0000;
        mask      = 16'h0000;
        repeat (2) @(negedge clk);

        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_dir", 32'(dir), 0);
        chk("rst_fb", 32'(fallback), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_lfsr", 32'(lfsr), 0);

        // First draw from natural LFSR: 0000 in IDLE, 0001 in DRAW
        rst  = 1'b0;
        req  = 4'b0001;
        mask = 16'h0002;
        push(4'b0001, 2'd1, 1'b0, 2);
        wait_grant(0, "t1");
        req = 4'b0000;
        chk("t1_lfsr3", 32'(lfsr), 32'h0003);
        @(negedge clk);
        chk("t1_lfsr7", 32'(lfsr), 32'h0007);
        chk("t1_idle", 32'(busy), 0);
        @(negedge clk);
        chk("t1_lfsrf", 32'(lfsr), 32'h000F);

        // Freeze LFSR at 0002 -> every candidate is direction 2
        seed_load = 1'b1;
        seed      = 16'h0002;
        @(negedge clk);
        chk("seed", 32'(lfsr), 32'h0002);

        mask = 16'h0004;
        req  = 4'b0001;
        push(4'b0001, 2'd2, 1'b0, 2);
        wait_grant(0, "t2");
        req = 4'b0000;
        @(negedge clk);

        // Fallback to lowest legal bit; mask edit and withdrawal ignored
        mask = 16'h0009;
        req  = 4'b0001;
        push(4'b0001, 2'd0, 1'b1, 5);
        @(negedge clk);
        chk("t3_busy", 32'(busy), 1);
        chk("t3_nognt", 32'(gnt), 0);
        req  = 4'b0000;
        mask = 16'h0004;
        wait_grant(1, "t3");
        @(negedge clk);

        mask = 16'h0008;
        req  = 4'b0001;
        push(4'b0001, 2'd3, 1'b1, 5);
        wait_grant(0, "t4");
        req = 4'b0000;
        @(negedge clk);

        mask = 16'h0000;
        req  = 4'b0001;
        push(4'b0001, 2'd0, 1'b1, 5);
        wait_grant(0, "t5");
        req = 4'b0000;
        @(negedge clk);

        // Reset mid-draw for ghost 1; rr_ptr must return to the last ghost
        mask = 16'hFFFF;
        req  = 4'b0010;
        @(negedge clk);
        chk("t6_busy", 32'(busy), 1);
        rst = 1'b1;
        req = 4'b0000;
        @(negedge clk);
        chk("t6_rbusy", 32'(busy), 0);
        chk("t6_rgnt", 32'(gnt), 0);
        chk("t6_rlfsr", 32'(lfsr), 0);
        rst = 1'b0;
        req = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            push(4'(1 << i), 2'd2, 1'b0, 2);
        end
        for (int i = 0; i < 4; i++) begin
            wait_grant(0, $sformatf("rot%0d", i));
            req[i] = 1'b0;
            @(negedge clk);
        end
        chk("rot_idle", 32'(busy), 0);
        chk("sb_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
